// File: rtl/instr_encoder.sv
`default_nettype none
// ============================================================================
// Module      : instr_encoder
// Description : Packs an opcode, register fields and a full-width immediate
//               into a 32-bit LEGv8 instruction word. The immediate is
//               range-checked against the field width of its format. Each
//               accepted word is written into instruction memory at an
//               auto-incrementing address. This lets the loader path build
//               programs without an external assembler.
//
// Ports       : clk        - clock, rising edge
//               reset      - asynchronous, active-high
//               start      - pulse: load address from base_addr, clear
//                            count/full/err, abort any in-flight request
//               base_addr  - first write address
//               in_valid   - encode request valid
//               in_ready   - encoder can accept a request
//               fmt        - 0=R 1=SHIFT 2=I 3=D 4=CB 5=B 6=IW (7 illegal)
//               opcode     - opcode, left-aligned to instruction[31:21]
//               rd/rn/rm   - register fields (rm used by R only)
//               imm        - full-width immediate
//               mem_we     - one-cycle write strobe
//               mem_addr   - write address
//               mem_wdata  - encoded instruction word
//               count      - words written since start
//               full       - address space exhausted
//               err        - sticky: a request was rejected
//
// Options     : ENCODE_VERIFY_EN - insert a VERIFY state that re-extends the
//               packed immediate field as the decoder would and compares it
//               with the requested immediate before writing.
//
// Revision    : 1.0 - initial release
// ============================================================================
module instr_encoder #(
    parameter int WORD      = 64,
    parameter int INSTR_LEN = 32,
    parameter int ADDR_W    = 10
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic [ADDR_W-1:0]    base_addr,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [2:0]           fmt,
    input  logic [10:0]          opcode,
    input  logic [4:0]           rd,
    input  logic [4:0]           rn,
    input  logic [4:0]           rm,
    input  logic [WORD-1:0]      imm,
    output logic                 mem_we,
    output logic [ADDR_W-1:0]    mem_addr,
    output logic [INSTR_LEN-1:0] mem_wdata,
    output logic [ADDR_W:0]      count,
    output logic                 full,
    output logic                 err
);

    // ------------------------------------------------------------------
    // Format codes
    // ------------------------------------------------------------------
    localparam logic [2:0] c_FMT_R     = 3'd0;
    localparam logic [2:0] c_FMT_SHIFT = 3'd1;
    localparam logic [2:0] c_FMT_I     = 3'd2;
    localparam logic [2:0] c_FMT_D     = 3'd3;
    localparam logic [2:0] c_FMT_CB    = 3'd4;
    localparam logic [2:0] c_FMT_B     = 3'd5;
    localparam logic [2:0] c_FMT_IW    = 3'd6;

    // ------------------------------------------------------------------
    // FSM encoding. S_VERIFY is only reachable when the verify option is
    // built in.
    // ------------------------------------------------------------------
    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_CHECK  = 2'd1,
        S_VERIFY = 2'd2,
        S_WRITE  = 2'd3
    } state_t;

    state_t r_state;
    state_t w_next_state;

    // Latched request
    logic [2:0]           r_fmt;
    logic [10:0]          r_opcode;
    logic [4:0]           r_rd;
    logic [4:0]           r_rn;
    logic [4:0]           r_rm;
    logic [WORD-1:0]      r_imm;

    // Write-port and status registers
    logic [ADDR_W-1:0]    r_addr;
    logic [INSTR_LEN-1:0] r_wdata;
    logic [ADDR_W:0]      r_count;
    logic                 r_full;
    logic                 r_err;

    logic                 w_accept;
    logic                 w_fit;
    logic [INSTR_LEN-1:0] w_packed;

    // start wins over a simultaneous request, so it blocks acceptance.
    assign w_accept = (r_state == S_IDLE) & in_valid & ~r_full & ~start;

    // ------------------------------------------------------------------
    // Range check. A signed N-bit field fits when every bit from the sign
    // position upward matches, i.e. imm[WORD-1:N-1] is all zeros or all
    // ones. IW is an unsigned 16-bit field. Illegal fmt never fits.
    // ------------------------------------------------------------------
    logic w_fit_shift;
    logic w_fit_i;
    logic w_fit_d;
    logic w_fit_cb;
    logic w_fit_b;
    logic w_fit_iw;

    assign w_fit_shift = (&r_imm[WORD-1:5])  | ~(|r_imm[WORD-1:5]);
    assign w_fit_i     = (&r_imm[WORD-1:11]) | ~(|r_imm[WORD-1:11]);
    assign w_fit_d     = (&r_imm[WORD-1:8])  | ~(|r_imm[WORD-1:8]);
    assign w_fit_cb    = (&r_imm[WORD-1:18]) | ~(|r_imm[WORD-1:18]);
    assign w_fit_b     = (&r_imm[WORD-1:25]) | ~(|r_imm[WORD-1:25]);
    assign w_fit_iw    = ~(|r_imm[WORD-1:16]);

    always_comb begin
        w_fit = 1'b0;
        case (r_fmt)
            c_FMT_R:     w_fit = 1'b1;
            c_FMT_SHIFT: w_fit = w_fit_shift;
            c_FMT_I:     w_fit = w_fit_i;
            c_FMT_D:     w_fit = w_fit_d;
            c_FMT_CB:    w_fit = w_fit_cb;
            c_FMT_B:     w_fit = w_fit_b;
            c_FMT_IW:    w_fit = w_fit_iw;
            default:     w_fit = 1'b0;
        endcase
    end

    // ------------------------------------------------------------------
    // Packing. The opcode occupies [31:21]. Wide immediate fields (I, CB,
    // B) are overlaid afterwards and overwrite the low opcode bits they
    // cover.
    // ------------------------------------------------------------------
    always_comb begin
        w_packed        = '0;
        w_packed[31:21] = r_opcode;
        case (r_fmt)
            c_FMT_R: begin
                w_packed[20:16] = r_rm;
                w_packed[9:5]   = r_rn;
                w_packed[4:0]   = r_rd;
            end
            c_FMT_SHIFT: begin
                w_packed[15:10] = r_imm[5:0];
                w_packed[9:5]   = r_rn;
                w_packed[4:0]   = r_rd;
            end
            c_FMT_I: begin
                w_packed[21:10] = r_imm[11:0];
                w_packed[9:5]   = r_rn;
                w_packed[4:0]   = r_rd;
            end
            c_FMT_D: begin
                w_packed[20:12] = r_imm[8:0];
                w_packed[11:10] = 2'b00;
                w_packed[9:5]   = r_rn;
                w_packed[4:0]   = r_rd;
            end
            c_FMT_CB: begin
                w_packed[23:5]  = r_imm[18:0];
                w_packed[4:0]   = r_rd;
            end
            c_FMT_B: begin
                w_packed[25:0]  = r_imm[25:0];
            end
            c_FMT_IW: begin
                w_packed[20:5]  = r_imm[15:0];
                w_packed[4:0]   = r_rd;
            end
            default: begin
                w_packed[20:0]  = '0;
            end
        endcase
    end

`ifdef ENCODE_VERIFY_EN
    // ------------------------------------------------------------------
    // Re-extend the packed field from the registered word exactly as the
    // decode stage does. R carries no immediate, so it trivially matches.
    // ------------------------------------------------------------------
    logic [WORD-1:0] w_reext;
    logic            w_verify_ok;

    always_comb begin
        w_reext = r_imm;
        case (r_fmt)
            c_FMT_SHIFT: w_reext = {{(WORD-6){r_wdata[15]}},  r_wdata[15:10]};
            c_FMT_I:     w_reext = {{(WORD-12){r_wdata[21]}}, r_wdata[21:10]};
            c_FMT_D:     w_reext = {{(WORD-9){r_wdata[20]}},  r_wdata[20:12]};
            c_FMT_CB:    w_reext = {{(WORD-19){r_wdata[23]}}, r_wdata[23:5]};
            c_FMT_B:     w_reext = {{(WORD-26){r_wdata[25]}}, r_wdata[25:0]};
            c_FMT_IW:    w_reext = {{(WORD-16){1'b0}},        r_wdata[20:5]};
            default:     w_reext = r_imm;
        endcase
    end

    assign w_verify_ok = (w_reext == r_imm);
`endif

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next state and strobes
    // ------------------------------------------------------------------
    always_comb begin
        w_next_state = r_state;
        in_ready     = 1'b0;
        mem_we       = 1'b0;
        case (r_state)
            S_IDLE: begin
                // Gated by reset so in_ready stays low while reset is held.
                in_ready = ~r_full & ~reset;
                if (w_accept) begin
                    w_next_state = S_CHECK;
                end
            end
            S_CHECK: begin
                if (w_fit) begin
`ifdef ENCODE_VERIFY_EN
                    w_next_state = S_VERIFY;
`else
                    w_next_state = S_WRITE;
`endif
                end else begin
                    w_next_state = S_IDLE;
                end
            end
`ifdef ENCODE_VERIFY_EN
            S_VERIFY: begin
                w_next_state = w_verify_ok ? S_WRITE : S_IDLE;
            end
`endif
            S_WRITE: begin
                mem_we       = 1'b1;
                w_next_state = S_IDLE;
            end
            default: begin
                w_next_state = S_IDLE;
            end
        endcase
        if (start) begin
            w_next_state = S_IDLE;
        end
    end

    // ------------------------------------------------------------------
    // Datapath registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_fmt    <= '0;
            r_opcode <= '0;
            r_rd     <= '0;
            r_rn     <= '0;
            r_rm     <= '0;
            r_imm    <= '0;
            r_addr   <= '0;
            r_wdata  <= '0;
            r_count  <= '0;
            r_full   <= 1'b0;
            r_err    <= 1'b0;
        end else if (start) begin
            r_addr   <= base_addr;
            r_count  <= '0;
            r_full   <= 1'b0;
            r_err    <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_fmt    <= fmt;
                        r_opcode <= opcode;
                        r_rd     <= rd;
                        r_rn     <= rn;
                        r_rm     <= rm;
                        r_imm    <= imm;
                    end
                end
                S_CHECK: begin
                    if (w_fit) begin
                        r_wdata <= w_packed;
                    end else begin
                        r_err   <= 1'b1;
                    end
                end
`ifdef ENCODE_VERIFY_EN
                S_VERIFY: begin
                    if (!w_verify_ok) begin
                        r_err <= 1'b1;
                    end
                end
`endif
                S_WRITE: begin
                    r_count <= r_count + (ADDR_W+1)'(1);
                    // The address wraps naturally; writing the top word
                    // marks the space as exhausted.
                    r_addr  <= r_addr + ADDR_W'(1);
                    if (&r_addr) begin
                        r_full <= 1'b1;
                    end
                end
                default: begin
                    r_err <= r_err;
                end
            endcase
        end
    end

    assign mem_addr  = r_addr;
    assign mem_wdata = r_wdata;
    assign count     = r_count;
    assign full      = r_full;
    assign err       = r_err;

endmodule
`default_nettype wire

// File: tb/tb_instr_encoder.sv
`default_nettype none
// ============================================================================
// Module      : tb_instr_encoder
// Description : Self-checking bench for instr_encoder. A transaction-level
//               model predicts accept/write/status behaviour from the format
//               rules, and a per-cycle compare process checks the DUT
//               against it. Directed cases pin literal encodings.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_instr_encoder;

    localparam int WORD      = 64;
    localparam int INSTR_LEN = 32;
    localparam int ADDR_W    = 10;
`ifdef ENCODE_VERIFY_EN
    localparam int LAT = 3;
`else
    localparam int LAT = 2;
`endif

    logic                 clk = 1'b0;
    logic                 rst;
    logic                 start;
    logic [ADDR_W-1:0]    base_addr;
    logic                 in_valid;
    logic                 in_ready;
    logic [2:0]           fmt;
    logic [10:0]          opcode;
    logic [4:0]           rd;
    logic [4:0]           rn;
    logic [4:0]           rm;
    logic [WORD-1:0]      imm;
    logic                 mem_we;
    logic [ADDR_W-1:0]    mem_addr;
    logic [INSTR_LEN-1:0] mem_wdata;
    logic [ADDR_W:0]      count;
    logic                 full;
    logic                 err;

    instr_encoder #(
        .WORD      (WORD),
        .INSTR_LEN (INSTR_LEN),
        .ADDR_W    (ADDR_W)
    ) dut (
        .clk       (clk),
        .reset     (rst),
        .start     (start),
        .base_addr (base_addr),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .fmt       (fmt),
        .opcode    (opcode),
        .rd        (rd),
        .rn        (rn),
        .rm        (rm),
        .imm       (imm),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .count     (count),
        .full      (full),
        .err       (err)
    );

    always #5 clk = ~clk;

    // ------------------------------------------------------------------
    // Check bookkeeping
    // ------------------------------------------------------------------
    int n_checks = 0;
    int n_pass   = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", name, act, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------
    // Reference model helpers
    // ------------------------------------------------------------------
    function automatic void fmt_range(input logic [2:0] f, output longint lo, output longint hi);
        case (f)
            3'd1:    begin lo = -32;         hi = 31;            end
            3'd2:    begin lo = -2048;       hi = 2047;          end
            3'd3:    begin lo = -256;        hi = 255;           end
            3'd4:    begin lo = -(64'sd1 <<< 18); hi = (64'sd1 <<< 18) - 1; end
            3'd5:    begin lo = -(64'sd1 <<< 25); hi = (64'sd1 <<< 25) - 1; end
            3'd6:    begin lo = 0;           hi = 65535;         end
            default: begin lo = -1000;       hi = 1000;          end
        endcase
    endfunction

    function automatic bit m_fits(input logic [2:0] f, input logic [63:0] v);
        longint lo;
        longint hi;
        longint s;
        s = $signed(v);
        fmt_range(f, lo, hi);
        if (f == 3'd0) return 1'b1;
        if (f == 3'd7) return 1'b0;
        if (f == 3'd6) return (v < 64'd65536);
        return (s >= lo) && (s <= hi);
    endfunction

    function automatic logic [31:0] m_pack(input logic [2:0] f, input logic [10:0] op,
                                           input logic [4:0] d, input logic [4:0] n,
                                           input logic [4:0] m, input logic [63:0] v);
        logic [63:0] w;
        logic [63:0] regs;
        w    = 64'(op) << 21;
        regs = (64'(n) << 5) | 64'(d);
        case (f)
            3'd0: w = w | (64'(m) << 16) | regs;
            3'd1: w = w | ((v & 64'h3F) << 10) | regs;
            3'd2: w = (w & ~64'h0020_0000) | ((v & 64'hFFF) << 10) | regs;
            3'd3: w = w | ((v & 64'h1FF) << 12) | regs;
            3'd4: w = (w & ~64'h00E0_0000) | ((v & 64'h7FFFF) << 5) | 64'(d);
            3'd5: w = (w & ~64'h03E0_0000) | (v & 64'h03FF_FFFF);
            3'd6: w = w | ((v & 64'hFFFF) << 5) | 64'(d);
            default: w = w;
        endcase
        return w[31:0];
    endfunction

    // ------------------------------------------------------------------
    // Reference model: per accepted request, predicts the cycle of the
    // write strobe and the edge on which status (count/addr/full/err)
    // updates.
    // ------------------------------------------------------------------
    longint      cyc     = 0;
    longint      we_at   = -1;
    longint      pend_at = -1;
    bit          pend_ok = 1'b0;
    bit          m_busy  = 1'b0;
    bit          m_full  = 1'b0;
    bit          m_err   = 1'b0;
    bit          exp_we  = 1'b0;
    int          m_addr  = 0;
    int          m_count = 0;
    int          exp_waddr = 0;
    logic [31:0] exp_wdata = '0;

    initial begin
        forever begin
            @(posedge clk or posedge rst);
            if (rst) begin
                m_addr  = 0;
                m_count = 0;
                m_full  = 1'b0;
                m_err   = 1'b0;
                m_busy  = 1'b0;
                exp_we  = 1'b0;
                we_at   = -1;
                pend_at = -1;
            end else begin
                cyc++;
                exp_we = 1'b0;
                if (start) begin
                    m_addr  = int'(base_addr);
                    m_count = 0;
                    m_full  = 1'b0;
                    m_err   = 1'b0;
                    m_busy  = 1'b0;
                    we_at   = -1;
                    pend_at = -1;
                end else if (m_busy) begin
                    if (cyc == we_at) begin
                        exp_we    = 1'b1;
                        exp_waddr = m_addr;
                    end
                    if (cyc == pend_at) begin
                        if (pend_ok) begin
                            m_count++;
                            if (m_addr == (1 << ADDR_W) - 1) m_full = 1'b1;
                            m_addr = (m_addr + 1) % (1 << ADDR_W);
                        end else begin
                            m_err = 1'b1;
                        end
                        m_busy = 1'b0;
                    end
                end else if (in_valid && !m_full) begin
                    m_busy = 1'b1;
                    if (m_fits(fmt, imm)) begin
                        pend_ok   = 1'b1;
                        exp_wdata = m_pack(fmt, opcode, rd, rn, rm, imm);
                        we_at     = cyc + LAT - 1;
                        pend_at   = cyc + LAT;
                    end else begin
                        pend_ok = 1'b0;
                        we_at   = -1;
                        pend_at = cyc + 1;
                    end
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Per-cycle compare against the model
    // ------------------------------------------------------------------
    initial begin
        forever begin
            @(negedge clk);
            chk("in_ready", in_ready, 64'(!rst && !m_busy && !m_full));
            chk("mem_we", mem_we, 64'(exp_we));
            if (exp_we) begin
                chk("wr_addr", mem_addr, 64'(exp_waddr));
                chk("wr_data", mem_wdata, exp_wdata);
            end
            chk("mem_addr", mem_addr, 64'(m_addr));
            chk("count", count, 64'(m_count));
            chk("full", full, 64'(m_full));
            chk("err", err, 64'(m_err));
        end
    end

    // ------------------------------------------------------------------
    // Stimulus tasks (called at a falling edge, return at a falling edge)
    // ------------------------------------------------------------------
    task automatic pulse_start(input logic [ADDR_W-1:0] b);
        start     = 1'b1;
        base_addr = b;
        @(negedge clk);
        start     = 1'b0;
    endtask

    task automatic send(input logic [2:0] f, input logic [10:0] op, input logic [4:0] d,
                        input logic [4:0] n, input logic [4:0] m, input logic [63:0] v,
                        input bit with_start, input int max_wait, output bit acc);
        bit will;
        in_valid = 1'b1;
        fmt      = f;
        opcode   = op;
        rd       = d;
        rn       = n;
        rm       = m;
        imm      = v;
        start    = with_start;
        acc      = 1'b0;
        for (int i = 0; i < max_wait && !acc; i++) begin
            will = in_ready && !start;
            @(negedge clk);
            start = 1'b0;
            if (will) acc = 1'b1;
        end
        in_valid = 1'b0;
    endtask

    function automatic logic [63:0] rand_imm(input logic [2:0] f);
        longint lo;
        longint hi;
        longint v;
        int     sel;
        fmt_range(f, lo, hi);
        sel = int'($urandom % 4);
        case (sel)
            0: v = longint'({$urandom, $urandom});
            1: v = lo + (longint'($urandom) % (hi - lo + 1));
            2: begin
                case ($urandom % 4)
                    0: v = lo;
                    1: v = hi;
                    2: v = lo - 1;
                    default: v = hi + 1;
                endcase
            end
            default: v = longint'($urandom % 8) - 4;
        endcase
        return 64'(v);
    endfunction

    // ------------------------------------------------------------------
    // Watchdog
    // ------------------------------------------------------------------
    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

    // ------------------------------------------------------------------
    // Main sequence
    // ------------------------------------------------------------------
    initial begin
        bit          acc;
        int          we_seen;
        logic [2:0]  rf;
        logic [63:0] rv;
        logic [ADDR_W-1:0] rb;

        rst       = 1'b1;
        start     = 1'b0;
        base_addr = '0;
        in_valid  = 1'b0;
        fmt       = '0;
        opcode    = '0;
        rd        = '0;
        rn        = '0;
        rm        = '0;
        imm       = '0;

        // Reset values
        @(negedge clk);
        chk("rst_in_ready", in_ready, 0);
        chk("rst_mem_we", mem_we, 0);
        chk("rst_mem_addr", mem_addr, 0);
        chk("rst_mem_wdata", mem_wdata, 0);
        chk("rst_count", count, 0);
        chk("rst_full", full, 0);
        chk("rst_err", err, 0);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("ready_after_rst", in_ready, 1);

        // ADDI: I-format
        pulse_start(10'h010);
        send(3'd2, 11'h488, 5'd2, 5'd1, 5'd0, 64'd5, 1'b0, 20, acc);
        chk("addi_accept", acc, 1);
        repeat (LAT - 1) @(negedge clk);
        chk("addi_we", mem_we, 1);
        chk("addi_addr", mem_addr, 64'h010);
        chk("addi_data", mem_wdata, 64'h9100_1422);
        @(negedge clk);
        chk("addi_count", count, 1);
        chk("addi_next_addr", mem_addr, 64'h011);

        // STUR: D-format, negative offset
        send(3'd3, 11'h7C0, 5'd4, 5'd3, 5'd0, 64'hFFFF_FFFF_FFFF_FFF8, 1'b0, 20, acc);
        chk("stur_accept", acc, 1);
        repeat (LAT - 1) @(negedge clk);
        chk("stur_we", mem_we, 1);
        chk("stur_addr", mem_addr, 64'h011);
        chk("stur_data", mem_wdata, 64'hF81F_8064);
        @(negedge clk);
        chk("stur_count", count, 2);

        // CBZ with out-of-range offset
        send(3'd4, 11'h5A0, 5'd5, 5'd0, 5'd0, 64'h4_0000, 1'b0, 20, acc);
        chk("cbz_accept", acc, 1);
        @(negedge clk);
        chk("cbz_err", err, 1);
        we_seen = 0;
        repeat (3) begin
            if (mem_we) we_seen++;
            @(negedge clk);
        end
        chk("cbz_no_write", we_seen, 0);
        chk("cbz_count", count, 2);

        // Address exhaustion
        pulse_start(10'h3FF);
        send(3'd5, 11'h0A0, 5'd0, 5'd0, 5'd0, 64'd100, 1'b0, 20, acc);
        chk("full_first_accept", acc, 1);
        repeat (LAT - 1) @(negedge clk);
        chk("full_we", mem_we, 1);
        chk("full_wr_addr", mem_addr, 64'h3FF);
        @(negedge clk);
        chk("full_flag", full, 1);
        chk("full_ready", in_ready, 0);
        chk("full_wrap_addr", mem_addr, 0);
        send(3'd5, 11'h0A0, 5'd0, 5'd0, 5'd0, 64'd200, 1'b0, 8, acc);
        chk("full_block", acc, 0);
        pulse_start(10'h000);
        chk("full_cleared", full, 0);
        chk("full_ready_again", in_ready, 1);

        // Abort during CHECK
        pulse_start(10'h123);
        send(3'd2, 11'h488, 5'd1, 5'd2, 5'd0, 64'd7, 1'b0, 20, acc);
        chk("abort_accept", acc, 1);
        pulse_start(10'h200);
        chk("abort_count", count, 0);
        chk("abort_addr", mem_addr, 64'h200);
        we_seen = 0;
        repeat (4) begin
            if (mem_we) we_seen++;
            @(negedge clk);
        end
        chk("abort_no_write", we_seen, 0);

        // Reset asserted while the write strobe is high
        pulse_start(10'h050);
        send(3'd6, 11'h694, 5'd9, 5'd0, 5'd0, 64'hBEEF, 1'b0, 20, acc);
        chk("rmw_accept", acc, 1);
        repeat (LAT - 2) @(negedge clk);
        @(posedge clk);
        #2;
        chk("rmw_we_high", mem_we, 1);
        rst = 1'b1;
        #1;
        chk("rmw_we_drop", mem_we, 0);
        chk("rmw_addr", mem_addr, 0);
        chk("rmw_wdata", mem_wdata, 0);
        chk("rmw_count", count, 0);
        chk("rmw_ready", in_ready, 0);
        @(negedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        pulse_start(10'h060);
        send(3'd1, 11'h69B, 5'd3, 5'd4, 5'd0, 64'd17, 1'b0, 20, acc);
        chk("resume_accept", acc, 1);
        repeat (LAT - 1) @(negedge clk);
        chk("resume_we", mem_we, 1);
        chk("resume_addr", mem_addr, 64'h060);

        // Randomized traffic
        for (int k = 0; k < 400; k++) begin
            if (m_full || ($urandom % 100) < 3) begin
                rb = ($urandom % 4 == 0) ? ADDR_W'(10'h3FC + ($urandom % 4)) : ADDR_W'($urandom);
                pulse_start(rb);
            end
            rf = 3'($urandom % 8);
            rv = rand_imm(rf);
            send(rf, 11'($urandom), 5'($urandom), 5'($urandom), 5'($urandom), rv,
                 ($urandom % 20) == 0, 20, acc);
            chk("rand_accept", acc, 64'(!m_full));
            if (acc && ($urandom % 25) == 0) begin
                repeat ($urandom % LAT) @(negedge clk);
                pulse_start(ADDR_W'($urandom));
            end
            repeat ($urandom % 3) @(negedge clk);
        end

        repeat (6) @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
